// File: rtl/comparator_seq_ctrl.sv
// Sequential magnitude comparator controller: walks two SLICES*3-bit operands LSB-slice first
// through an external 3-bit cascadable comparator and reports lt/eq/gt plus a sticky error.
module comparator_seq_ctrl #(
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3*SLICES-1:0]   a_in,
    input  logic [3*SLICES-1:0]   b_in,
    output logic [2:0]            sl_a,
    output logic [2:0]            sl_b,
    output logic                  sl_l,
    output logic                  sl_e,
    output logic                  sl_g,
    input  logic                  sl_lt,
    input  logic                  sl_eq,
    input  logic                  sl_gt,
    output logic                  busy,
    output logic                  done,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt,
    output logic                  err
);

    localparam int W     = 3 * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [2:0]       casc_reg;
    logic [2:0]       res_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic [2:0]       a_slice [SLICES];
    logic [2:0]       b_slice [SLICES];
    logic [2:0]       slice_res;
    logic             last_slice;

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[3*gi +: 3];
            assign b_slice[gi] = b_reg[3*gi +: 3];
        end
    endgenerate

    assign slice_res  = {sl_lt, sl_eq, sl_gt};
    assign last_slice = (idx_reg == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            casc_reg  <= 3'b010;
            res_reg   <= 3'b000;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        idx_reg   <= '0;
                        casc_reg  <= 3'b010;
                        res_reg   <= 3'b000;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A malformed slice result aborts the walk; the partial answer is meaningless.
                    if (!$onehot(slice_res)) begin
                        err_reg   <= 1'b1;
                        res_reg   <= 3'b000;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end else if (last_slice) begin
                        res_reg   <= slice_res;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        casc_reg <= slice_res;
                        idx_reg  <= idx_reg + 1'b1;
                    end
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    casc_reg  <= 3'b010;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Slices are only presented while walking; otherwise the comparator sees a neutral input.
    assign sl_a = (state_reg == RUN) ? a_slice[idx_reg] : 3'b000;
    assign sl_b = (state_reg == RUN) ? b_slice[idx_reg] : 3'b000;
    assign sl_l = (state_reg == RUN) ? casc_reg[2] : 1'b0;
    assign sl_e = (state_reg == RUN) ? casc_reg[1] : 1'b1;
    assign sl_g = (state_reg == RUN) ? casc_reg[0] : 1'b0;

    assign busy = busy_reg;
    assign done = done_reg;
    assign lt   = res_reg[2];
    assign eq   = res_reg[1];
    assign gt   = res_reg[0];
    assign err  = err_reg;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Directed bench for comparator_seq_ctrl with a behavioural 3-bit cascadable comparator
// attached to the slice port; one line per completed transaction.
module tb_comparator_seq_ctrl;

    localparam int SLICES = 4;
    localparam int W      = 3 * SLICES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   sl_a, sl_b;
    logic         sl_l, sl_e, sl_g;
    logic         sl_lt, sl_eq, sl_gt;
    logic         busy, done, lt, eq, gt, err;
    logic         fault_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    comparator_seq_ctrl #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .sl_a  (sl_a),
        .sl_b  (sl_b),
        .sl_l  (sl_l),
        .sl_e  (sl_e),
        .sl_g  (sl_g),
        .sl_lt (sl_lt),
        .sl_eq (sl_eq),
        .sl_gt (sl_gt),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Reference 3-bit cascadable comparator: {lt,eq,gt}; equal slices pass the cascade through.
    function automatic logic [2:0] cmp_model(input logic [2:0] a3, input logic [2:0] b3,
                                             input logic [2:0] casc);
        if (a3 > b3)      return 3'b001;
        else if (a3 < b3) return 3'b100;
        else              return casc;
    endfunction

    always_comb begin
        {sl_lt, sl_eq, sl_gt} = cmp_model(sl_a, sl_b, {sl_l, sl_e, sl_g});
        if (fault_on) {sl_lt, sl_eq, sl_gt} = 3'b110;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge. fault_k >= 0 corrupts that slice's result.
    // hold keeps start high and scrambles operands during the run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] exp_res, input logic exp_err,
                          input int fault_k, input bit hold);
        logic [2:0] prev;
        int         n;
        logic [2:0] sa, sb;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_acc", busy, 1);
        check("err_clr", err, 0);
        check("res_clr", {lt, eq, gt}, 3'b000);
        prev = 3'b010;
        n = (fault_k >= 0) ? fault_k + 1 : SLICES;
        for (int k = 0; k < n; k++) begin
            sa = a[3*k +: 3];
            sb = b[3*k +: 3];
            check($sformatf("sl_a[%0d]", k), sl_a, sa);
            check($sformatf("sl_b[%0d]", k), sl_b, sb);
            check($sformatf("casc[%0d]", k), {sl_l, sl_e, sl_g}, prev);
            check($sformatf("done_run[%0d]", k), done, 0);
            if (hold) begin
                a_in = ~a_in;
                b_in = b_in + 1'b1;
            end
            if (k == fault_k) fault_on = 1'b1;
            else prev = cmp_model(sa, sb, prev);
            @(negedge clk);
            fault_on = 1'b0;
        end
        check("done_fin", done, 1);
        check("busy_fin", busy, 1);
        check("res_fin", {lt, eq, gt}, exp_res);
        check("err_fin", err, exp_err);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("res_held", {lt, eq, gt}, exp_res);
        check("err_held", err, exp_err);
        check("sl_idle", {sl_a, sl_b}, 6'd0);
        check("casc_idle", {sl_l, sl_e, sl_g}, 3'b010);
        $display("op a=%03h b=%03h -> lt/eq/gt=%b err=%b", a, b, {lt, eq, gt}, err);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {lt, eq, gt}, 3'b000);
        check("rst_err", err, 0);
        check("rst_casc", {sl_l, sl_e, sl_g}, 3'b010);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(12'h249, 12'h249, 3'b010, 1'b0, -1, 1'b0);
        run_op(12'h800, 12'h7FF, 3'b001, 1'b0, -1, 1'b0);
        run_op(12'h001, 12'h002, 3'b100, 1'b0, -1, 1'b0);
        run_op(12'h5A3, 12'h5A4, 3'b100, 1'b0, -1, 1'b0);

        // start held through the whole op, operands changing; FIN start ignored, next IDLE accepted
        run_op(12'h123, 12'h122, 3'b001, 1'b0, -1, 1'b1);
        run_op(12'h3C0, 12'h3C0, 3'b010, 1'b0, -1, 1'b0);

        run_op(12'h777, 12'h111, 3'b000, 1'b1, 1, 1'b0);
        run_op(12'h111, 12'h777, 3'b100, 1'b0, -1, 1'b0);

        // reset during RUN aborts silently
        a_in  = 12'hABC;
        b_in  = 12'h123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_res", {lt, eq, gt}, 3'b000);
        check("arst_sl", {sl_a, sl_b}, 6'd0);
        check("arst_casc", {sl_l, sl_e, sl_g}, 3'b010);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < SLICES + 2; i++) begin
            @(negedge clk);
            check($sformatf("no_done[%0d]", i), {busy, done}, 2'b00);
        end
        run_op(12'h010, 12'h008, 3'b001, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
